rbs_reg_pipe: RTL and testbench

Pipelined, registered ripple-borrow subtractor computing `a_i - b_i` over `WIDTH` bits. The borrow chain is split into `STAGES` equal segments with a register between segments, so each cycle only one segment of borrow ripple is on the critical path. It is the subtraction counterpart to the team's registered ripple-carry adders. A valid/ready handshake on both sides lets it sit between streaming producers and consumers, with full-pipeline stall on backpressure.

---
 rtl/rbs_reg_pipe.sv | 123 ++++++++++++
 tb/tb_rbs_reg_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rbs_reg_pipe.sv
// Pipelined ripple-borrow subtractor: a_i - b_i split into STAGES borrow segments,
// with valid/ready flow control and a full-pipeline stall on backpressure.
module rbs_reg_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic             ovf_o
);

   localparam int unsigned SEG = WIDTH / STAGES;

   // Single shallow enable shared by every stage register; out_ready arrives late.
   logic advance;
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int unsigned LO = k * SEG;
      localparam int unsigned HI = LO + SEG;

      logic            valid_in;
      logic            valid_q;
      logic [SEG-1:0]  sa;
      logic [SEG-1:0]  sb;
      logic            bin;
      logic [SEG-1:0]  seg_d;
      logic            seg_bout;
      logic [HI-1:0]   diff_nxt;
      logic [HI-1:0]   diff_q;
      logic            borrow_q;

      if (k == 0) begin : g_src
         assign valid_in = in_valid;
         assign sa       = a_i[SEG-1:0];
         assign sb       = b_i[SEG-1:0];
         assign bin      = 1'b0;
         assign diff_nxt = seg_d;
      end else begin : g_src
         assign valid_in = g_stg[k-1].valid_q;
         assign sa       = g_stg[k-1].g_skew.a_q[HI-1:LO];
         assign sb       = g_stg[k-1].g_skew.b_q[HI-1:LO];
         assign bin      = g_stg[k-1].borrow_q;
         assign diff_nxt = {seg_d, g_stg[k-1].diff_q};
      end

      // One segment of borrow ripple.
      always_comb begin
         logic br;
         br    = bin;
         seg_d = '0;
         for (int unsigned j = 0; j < SEG; j++) begin
            seg_d[j] = sa[j] ^ sb[j] ^ br;
            br       = (~sa[j] & sb[j]) | (~sa[j] & br) | (sb[j] & br);
         end
         seg_bout = br;
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            valid_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
         end else if (advance) begin
            valid_q  <= valid_in;
            diff_q   <= diff_nxt;
            borrow_q <= seg_bout;
         end
      end

      if (k + 1 < STAGES) begin : g_skew
         // Operand bits not yet consumed travel alongside the partial difference.
         logic [WIDTH-1:HI] a_nxt;
         logic [WIDTH-1:HI] b_nxt;
         logic [WIDTH-1:HI] a_q;
         logic [WIDTH-1:HI] b_q;

         if (k == 0) begin : g_ld
            assign a_nxt = a_i[WIDTH-1:HI];
            assign b_nxt = b_i[WIDTH-1:HI];
         end else begin : g_ld
            assign a_nxt = g_stg[k-1].g_skew.a_q[WIDTH-1:HI];
            assign b_nxt = g_stg[k-1].g_skew.b_q[WIDTH-1:HI];
         end

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_nxt;
               b_q <= b_nxt;
            end
         end
      end else begin : g_last
         // Last segment holds the operand MSBs, so signed overflow is resolved here.
         logic ovf_q;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= (sa[SEG-1] ^ sb[SEG-1]) & (sa[SEG-1] ^ seg_d[SEG-1]);
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].valid_q;
   assign diff_o    = g_stg[STAGES-1].diff_q;
   assign borrow_o  = g_stg[STAGES-1].borrow_q;
   assign ovf_o     = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_rbs_reg_pipe.sv
// Self-checking bench for rbs_reg_pipe: directed vectors, handshake corners,
// random scoreboard traffic, and a STAGES=1/4/8 sweep against an arithmetic model.
module tb_rbs_reg_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a_i, b_i, diff_o;
   logic       borrow_o, ovf_o;

   rbs_reg_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .a_i(a_i), .b_i(b_i), .out_valid(out_valid), .out_ready(out_ready),
      .diff_o(diff_o), .borrow_o(borrow_o), .ovf_o(ovf_o));

   logic       s_valid, s_ready;
   logic [7:0] s_a, s_b;
   logic [2:0] s_ir, s_ov, s_bo, s_of;
   logic [7:0] s_d [3];

   rbs_reg_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
      .clk(clk), .rstn(rstn), .in_valid(s_valid), .in_ready(s_ir[0]),
      .a_i(s_a), .b_i(s_b), .out_valid(s_ov[0]), .out_ready(s_ready),
      .diff_o(s_d[0]), .borrow_o(s_bo[0]), .ovf_o(s_of[0]));
   rbs_reg_pipe #(.WIDTH(8), .STAGES(4)) u_s4 (
      .clk(clk), .rstn(rstn), .in_valid(s_valid), .in_ready(s_ir[1]),
      .a_i(s_a), .b_i(s_b), .out_valid(s_ov[1]), .out_ready(s_ready),
      .diff_o(s_d[1]), .borrow_o(s_bo[1]), .ovf_o(s_of[1]));
   rbs_reg_pipe #(.WIDTH(8), .STAGES(8)) u_s8 (
      .clk(clk), .rstn(rstn), .in_valid(s_valid), .in_ready(s_ir[2]),
      .a_i(s_a), .b_i(s_b), .out_valid(s_ov[2]), .out_ready(s_ready),
      .diff_o(s_d[2]), .borrow_o(s_bo[2]), .ovf_o(s_of[2]));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, returns {diff, borrow, ovf}.
   function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
      int ud, sd;
      logic [7:0] d;
      ud = int'(a) - int'(b);
      sd = int'($signed(a)) - int'($signed(b));
      d  = 8'(ud);
      return {d, (ud < 0), (sd > 127 || sd < -128)};
   endfunction

   typedef struct {
      logic [7:0] a, b, d;
      logic       bo, ov;
   } vec_t;
   vec_t tbl [10];

   logic [9:0]  sb_q [$];
   logic        prev_stall = 1'b0;
   logic [10:0] prev_out;
   int          cyc = 0, pops = 0, tp_first = -1, tp_last = -1;

   // One cycle of main-DUT traffic: drive, observe the handshake about to happen, advance.
   task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic ordy);
      logic [9:0] exp;
      in_valid = iv; a_i = a; b_i = b; out_ready = ordy;
      #1;
      if (prev_stall) chk("stall_hold", {out_valid, diff_o, borrow_o, ovf_o}, prev_out);
      prev_stall = out_valid & ~out_ready;
      prev_out   = {out_valid, diff_o, borrow_o, ovf_o};
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL spurious_out: got diff 0x%0h with nothing outstanding at %0t", diff_o, $time);
         end else begin
            exp = sb_q.pop_front();
            chk("result", {diff_o, borrow_o, ovf_o}, exp);
         end
         pops++;
         if (tp_first < 0) tp_first = cyc;
         tp_last = cyc;
      end
      if (in_valid && in_ready) sb_q.push_back(ref_sub(a, b));
      cyc++;
      @(negedge clk);
   endtask

   // Directed vector with latency measurement; expectations come from the table.
   task automatic issue_vec(input int i);
      int lat;
      in_valid = 1'b1; a_i = tbl[i].a; b_i = tbl[i].b; out_ready = 1'b1;
      #1 chk("vec_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      for (lat = 1; lat <= 12; lat++) begin
         if (out_valid) break;
         @(negedge clk);
      end
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_diff", i), diff_o, tbl[i].d);
      chk($sformatf("vec%0d_borrow", i), borrow_o, tbl[i].bo);
      chk($sformatf("vec%0d_ovf", i), ovf_o, tbl[i].ov);
      @(negedge clk);
   endtask

   localparam int NSW = 4096;
   logic [7:0] ha [NSW];
   logic [7:0] hb [NSW];

   initial begin
      logic [7:0] bp_a [3];
      logic [7:0] bp_b [3];
      logic [9:0] e;
      int         sv;

      tbl[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
      tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
      tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      tbl[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
      tbl[4] = '{8'h0F, 8'h0F, 8'h00, 1'b0, 1'b0};
      tbl[5] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
      tbl[6] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
      tbl[7] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
      tbl[8] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
      tbl[9] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};

      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;
      s_valid = 1'b0; s_ready = 1'b1; s_a = '0; s_b = '0;

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff_o, 0);
      chk("rst_borrow", borrow_o, 0);
      chk("rst_ovf", ovf_o, 0);
      chk("rst_sweep_valid", s_ov, 0);
      @(negedge clk);
      rstn = 1'b1;
      #1 chk("post_rst_in_ready", in_ready, 1);
      @(negedge clk);

      for (int i = 0; i < 10; i++) issue_vec(i);

      // Throughput: 16 back-to-back operations
      pops = 0; tp_first = -1; tp_last = -1; prev_stall = 1'b0;
      for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
      chk("tp_count", pops, 16);
      chk("tp_span", tp_last - tp_first, 15);

      // Backpressure: stall for 5 cycles with the first result at the output
      pops = 0;
      for (int i = 0; i < 3; i++) begin bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom); end
      e = ref_sub(bp_a[0], bp_b[0]);
      step(1'b1, bp_a[0], bp_b[0], 1'b0);
      step(1'b1, bp_a[1], bp_b[1], 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, bp_a[2], bp_b[2], 1'b0);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_first_result", {diff_o, borrow_o, ovf_o}, e);
      end
      step(1'b1, bp_a[2], bp_b[2], 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
      chk("bp_pops", pops, 3);
      chk("bp_drained", sb_q.size(), 0);

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
      chk("rand_drained", sb_q.size(), 0);

      // Reset with two operations in flight
      step(1'b1, 8'h33, 8'h11, 1'b1);
      step(1'b1, 8'h44, 8'h22, 1'b0);
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1 chk("rst_mid_out_valid", out_valid, 0);
      sb_q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00, 8'h00, 1'b1);
         chk("rst_mid_no_stale", out_valid, 0);
      end
      issue_vec(5);

      // Parameter sweep: STAGES = 1, 4, 8 fed in lockstep, checked against the model
      for (int t = 0; t < NSW; t++) begin
         s_valid = 1'b1;
         s_a = 8'(t);
         s_b = 8'($urandom);
         ha[t] = s_a;
         hb[t] = s_b;
         #1;
         for (int i = 0; i < 3; i++) begin
            sv = (i == 0) ? 1 : ((i == 1) ? 4 : 8);
            if (t >= sv) begin
               e = ref_sub(ha[t-sv], hb[t-sv]);
               chk($sformatf("sweep_s%0d", sv), {s_ov[i], s_d[i], s_bo[i], s_of[i]}, {1'b1, e});
            end else begin
               chk($sformatf("sweep_s%0d_fill", sv), {s_ov[i], s_ir[i]}, 2'b01);
            end
         end
         @(negedge clk);
      end
      s_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
